// File: rtl/i2c_target.sv
// I2C target (slave) responder: single 7-bit address, byte-stream receive strobe and fetch-handshake transmit.
// Latency: pad-to-filtered level is 2 sync + FILT_LEN samples; SDA drive changes the cycle after a filtered SCL fall.
// Backpressure: none; every written byte is ACKed and tx_data must be valid on the tx_req cycle.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   scl_in, sda_in      asynchronous pad levels
//   sda_oe              1 = pull SDA low (open drain)
//   rx_data, rx_valid   last byte written by the master, one-cycle strobe
//   tx_data, tx_req     read byte, sampled on the cycle tx_req is high
//   busy                address matched, until STOP or mismatch
//   nack_seen           one-cycle strobe, master NACKed a read byte
module i2c_target #(
    parameter logic [6:0] SLV_ADDR = 7'h42,
    parameter int         FILT_LEN = 3      // must be >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       nack_seen
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    localparam int ARM_CYC = FILT_LEN + 2;
    localparam int ARM_W   = $clog2(ARM_CYC + 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0]          scl_sync, sda_sync;
    logic [FILT_LEN-1:0] scl_hist, sda_hist;
    logic                scl_f, sda_f, scl_prev, sda_prev;
    logic [ARM_W-1:0]    arm_cnt;
    logic                armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
            arm_cnt  <= '0;
            armed    <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_hist <= {scl_hist[FILT_LEN-2:0], scl_sync[1]};
            sda_hist <= {sda_hist[FILT_LEN-2:0], sda_sync[1]};
            if (&scl_hist)       scl_f <= 1'b1;
            else if (~|scl_hist) scl_f <= 1'b0;
            if (&sda_hist)       sda_f <= 1'b1;
            else if (~|sda_hist) sda_f <= 1'b0;
            scl_prev <= scl_f;
            sda_prev <= sda_f;
            // The filter comes out of reset assuming an idle-high bus; hold off
            // edge detection until real pad levels have flushed through, so a
            // bus that is low at reset release never looks like a START.
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
                if (arm_cnt == ARM_W'(ARM_CYC)) armed <= 1'b1;
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  = armed & scl_f & ~scl_prev;
    assign scl_fall  = armed & ~scl_f & scl_prev;
    // While we pull SDA low, any SDA transition is our own doing, not framing.
    assign start_det = armed & ~sda_oe & scl_f & scl_prev & sda_prev & ~sda_f;
    assign stop_det  = armed & ~sda_oe & scl_f & scl_prev & ~sda_prev & sda_f;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    state_t      state, state_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        rw, rw_nxt;
    logic        sda_oe_nxt, rx_valid_nxt, busy_nxt, nack_seen_nxt;
    logic [7:0]  rx_data_nxt;
    logic [7:0]  byte_in;

    assign byte_in = {shreg[6:0], sda_f};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            nack_seen <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            rw        <= rw_nxt;
            sda_oe    <= sda_oe_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            busy      <= busy_nxt;
            nack_seen <= nack_seen_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        rw_nxt        = rw;
        sda_oe_nxt    = sda_oe;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        busy_nxt      = busy;
        nack_seen_nxt = 1'b0;
        tx_req        = 1'b0;

        if (stop_det) begin
            state_nxt   = IDLE;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
            bit_cnt_nxt = 3'd0;
        end else if (start_det) begin
            // busy is left alone: it is re-decided by the next address byte.
            state_nxt   = ADDR;
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 3'd0;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shreg_nxt   = byte_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_in[7:1] == SLV_ADDR) begin
                                state_nxt = ADDR_ACK;
                                busy_nxt  = 1'b1;
                                rw_nxt    = byte_in[0];
                            end else begin
                                state_nxt = IDLE;
                                busy_nxt  = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK, RX_ACK: begin
                    // sda_oe doubles as the ACK-slot phase: the first SCL fall
                    // starts the drive, the second one ends the ACK clock.
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nxt = 1'b1;
                        end else begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = 3'd0;
                            if (state == ADDR_ACK && rw) begin
                                tx_req     = 1'b1;
                                shreg_nxt  = tx_data;
                                sda_oe_nxt = ~tx_data[7];
                                state_nxt  = TX_BYTE;
                            end else begin
                                state_nxt = RX_BYTE;
                            end
                        end
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        shreg_nxt   = byte_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_nxt  = byte_in;
                            rx_valid_nxt = 1'b1;
                            state_nxt    = RX_ACK;
                        end
                    end
                end
                TX_BYTE: begin
                    // The MSB is already on the wire; each fall moves to the
                    // next bit, and the eighth fall hands SDA to the master.
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = 3'd0;
                            state_nxt   = TX_ACK;
                        end else begin
                            shreg_nxt   = {shreg[6:0], 1'b0};
                            sda_oe_nxt  = ~shreg[6];
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end
                TX_ACK: begin
                    // A NACK leaves on the rise, so any fall seen here follows an ACK.
                    if (scl_rise && sda_f) begin
                        nack_seen_nxt = 1'b1;
                        sda_oe_nxt    = 1'b0;
                        state_nxt     = WAIT_STOP;
                    end else if (scl_fall) begin
                        tx_req      = 1'b1;
                        shreg_nxt   = tx_data;
                        sda_oe_nxt  = ~tx_data[7];
                        bit_cnt_nxt = 3'd0;
                        state_nxt   = TX_BYTE;
                    end
                end
                WAIT_STOP: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;

    localparam int Q = 20;   // quarter SCL period in clk cycles

    logic       clk;
    logic       rst;
    logic       scl;
    logic       sda_m;      // master drive: 0 = pull low, 1 = release
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic       nack_seen;

    int checks = 0;
    int errors = 0;

    // monitor counters (monotonic, tests take differences)
    int rx_cnt = 0, tx_cnt = 0, nack_cnt = 0, oe_cnt = 0, busy_fall = 0, busy_hi = 0;
    logic busy_q = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target #(.SLV_ADDR(7'h42), .FILT_LEN(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .busy      (busy),
        .nack_seen (nack_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid)  rx_cnt   <= rx_cnt + 1;
        if (tx_req)    tx_cnt   <= tx_cnt + 1;
        if (nack_seen) nack_cnt <= nack_cnt + 1;
        if (sda_oe)    oe_cnt   <= oe_cnt + 1;
        if (busy)      busy_hi  <= busy_hi + 1;
        if (busy_q && !busy) busy_fall <= busy_fall + 1;
        busy_q <= busy;
    end

    // ---------------- bus master primitives ----------------
    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; wclk(Q);
        scl   = 1'b0; wclk(Q);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wclk(Q);
        scl   = 1'b1; wclk(Q);
        sda_m = 1'b0; wclk(Q);
        scl   = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wclk(Q);
        scl   = 1'b1; wclk(Q);
        sda_m = 1'b1; wclk(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wclk(Q);
        scl   = 1'b1; wclk(2 * Q);
        scl   = 1'b0; wclk(Q);
    endtask

    task automatic write_bit_glitch(input logic b);
        sda_m = b;    wclk(Q / 2);
        scl   = 1'b1; wclk(1);
        scl   = 1'b0; wclk(Q / 2);
        scl   = 1'b1; wclk(2 * Q);
        scl   = 1'b0; wclk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wclk(Q);
        scl   = 1'b1; wclk(Q);
        b     = sda_line;
        wclk(Q);
        scl   = 1'b0; wclk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack_bit);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack_bit);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; scl = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
        wclk(4);
        checks++; if (sda_oe !== 1'b0)    begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (tx_req !== 1'b0)    begin errors++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (nack_seen !== 1'b0) begin errors++; $display("FAIL reset_nack_seen: got %b want 0", nack_seen); end
        rst = 1'b0;
        wclk(20);
    endtask

    task automatic test_write1();
        logic a0, a1;
        int rx0 = rx_cnt;
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'hA5, a1);
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL wr1_addr_ack: got %b want 0", a0); end
        checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL wr1_data_ack: got %b want 0", a1); end
        checks++; if (rx_cnt - rx0 !== 1) begin errors++; $display("FAIL wr1_rx_count: got %0d want 1", rx_cnt - rx0); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL wr1_rx_data: got %h want a5", rx_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr1_busy_before_stop: got %b want 1", busy); end
        i2c_stop();
        wclk(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr1_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_mismatch();
        logic a0, a1;
        int rx0 = rx_cnt, oe0 = oe_cnt, bh0 = busy_hi;
        i2c_start();
        write_byte(8'h86, a0);
        write_byte(8'h11, a1);
        i2c_stop();
        wclk(10);
        checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL mis_addr_ack: got %b want 1", a0); end
        checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL mis_data_ack: got %b want 1", a1); end
        checks++; if (oe_cnt - oe0 !== 0) begin errors++; $display("FAIL mis_sda_oe_cycles: got %0d want 0", oe_cnt - oe0); end
        checks++; if (rx_cnt - rx0 !== 0) begin errors++; $display("FAIL mis_rx_count: got %0d want 0", rx_cnt - rx0); end
        checks++; if (busy_hi - bh0 !== 0) begin errors++; $display("FAIL mis_busy_cycles: got %0d want 0", busy_hi - bh0); end
    endtask

    task automatic test_read2();
        logic a0;
        logic [7:0] d0, d1;
        int tx0 = tx_cnt, nk0 = nack_cnt;
        tx_data = 8'h3C;
        i2c_start();
        write_byte(8'h85, a0);
        tx_data = 8'hF0;
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL rd2_addr_ack: got %b want 0", a0); end
        checks++; if (d0 !== 8'h3C) begin errors++; $display("FAIL rd2_byte0: got %h want 3c", d0); end
        checks++; if (d1 !== 8'hF0) begin errors++; $display("FAIL rd2_byte1: got %h want f0", d1); end
        checks++; if (tx_cnt - tx0 !== 2) begin errors++; $display("FAIL rd2_tx_req_count: got %0d want 2", tx_cnt - tx0); end
        checks++; if (nack_cnt - nk0 !== 1) begin errors++; $display("FAIL rd2_nack_count: got %0d want 1", nack_cnt - nk0); end
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd2_released_before_stop: got %b want 0", sda_oe); end
        i2c_stop();
        wclk(10);
    endtask

    task automatic test_rstart();
        logic a0, a1, a2;
        logic [7:0] d0;
        int bf0;
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h07, a1);
        bf0 = busy_fall;
        checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL rs_rx_data: got %h want 07", rx_data); end
        tx_data = 8'h99;
        i2c_rstart();
        write_byte(8'h85, a2);
        read_byte(d0, 1'b1);
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rs_acks: got %b want 000", {a0, a1, a2}); end
        checks++; if (d0 !== 8'h99) begin errors++; $display("FAIL rs_read_byte: got %h want 99", d0); end
        checks++; if (busy_fall - bf0 !== 0 || busy !== 1'b1) begin errors++; $display("FAIL rs_busy_held: falls %0d busy %b want 0 falls busy 1", busy_fall - bf0, busy); end
        i2c_stop();
        wclk(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rs_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_abort_glitch();
        logic a0, a1, a2;
        int rx0 = rx_cnt;
        i2c_start();
        write_byte(8'h84, a0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        wclk(10);
        checks++; if (rx_cnt - rx0 !== 0) begin errors++; $display("FAIL abort_rx_count: got %0d want 0", rx_cnt - rx0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'h84, a1);
        write_bit_glitch(1'b1);
        for (int i = 6; i >= 0; i--) write_bit(i == 6 || i == 1 || i == 0);
        read_bit(a2);
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL glitch_acks: got %b want 000", {a0, a1, a2}); end
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL glitch_rx_data: got %h want c3", rx_data); end
        checks++; if (rx_cnt - rx0 !== 1) begin errors++; $display("FAIL glitch_rx_count: got %0d want 1", rx_cnt - rx0); end
        i2c_stop();
        wclk(10);
    endtask

    task automatic test_reset_mid();
        logic a0, a1;
        int rx0;
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 2);   // 0x84
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstmid_ack_driven: got %b want 1", sda_oe); end
        rst = 1'b1;
        #1;
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstmid_release: got %b want 0", sda_oe); end
        checks++; if (busy !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_outputs: busy %b rx_data %h want 0 00", busy, rx_data); end
        wclk(3);
        rst = 1'b0;
        sda_m = 1'b1; wclk(Q);
        scl   = 1'b1; wclk(2 * Q);
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h5A, a1);
        checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL rstmid_acks: got %b want 00", {a0, a1}); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL rstmid_rx_data: got %h want 5a", rx_data); end
        checks++; if (rx_cnt - rx0 !== 1) begin errors++; $display("FAIL rstmid_rx_count: got %0d want 1", rx_cnt - rx0); end
        i2c_stop();
        wclk(10);
    endtask

    initial begin
        test_reset();
        test_write1();
        test_mismatch();
        test_read2();
        test_rstart();
        test_abort_glitch();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder on the bus side that faces the existing I2C master. It is the opposite end of the same SCL/SDA protocol.
- Serves as the on-chip I2C endpoint for loopback verification of the master, and as a simple byte-stream peripheral.
- Single 7-bit address. Receives write bytes into a strobed output and sources read bytes from a fetch handshake.
- Runs off the system clock and oversamples SCL/SDA.

Parameters:
- SLV_ADDR, 7'h42, 7-bit target address matched after START/repeated START.
- FILT_LEN, 3, synchronized-sample count an input level must hold before it is accepted (glitch filter).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- scl_in  input  1  SCL pad level (asynchronous).
- sda_in  input  1  SDA pad level (asynchronous).
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-cycle strobe; rx_data is valid.
- tx_data  input  8  byte to return on a read; sampled on the cycle tx_req is high.
- tx_req  output  1  one-cycle strobe requesting the next read byte.
- busy  output  1  high from an address match until STOP or address mismatch.
- nack_seen  output  1  one-cycle strobe; the master NACKed a read byte.

Behaviour:
- Reset values: sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, nack_seen=0, state=IDLE.
- Input conditioning: 2-FF synchronizer per line, then FILT_LEN-deep filter. Filtered levels scl_f/sda_f update only when FILT_LEN consecutive samples agree.
- Edge flags: scl_rise, scl_fall. START = sda_f 1->0 while scl_f=1. STOP = sda_f 0->1 while scl_f=1.
- Sampling: SDA is sampled on scl_rise. sda_oe changes only on the cycle after scl_fall, except START/STOP handling below.
- Bits are MSB first. Bit counter runs 0..7; the 9th clock is the ACK slot.

State machine:
- IDLE: wait for START -> ADDR.
- ADDR: shift 8 bits (7 address + R/W).
  - Address matches: -> ADDR_ACK, busy=1.
  - No match: -> IDLE; sda_oe stays 0 and busy stays 0.
- ADDR_ACK: sda_oe=1 from the scl_fall after bit 8 to the scl_fall after the 9th clock.
  - R/W=0: -> RX_BYTE.
  - R/W=1: tx_req pulses on the scl_fall ending the ACK slot; the byte is latched the following cycle; -> TX_BYTE.
- RX_BYTE: shift 8 bits. On the 8th scl_rise: rx_data <= shifted byte, rx_valid=1 for one cycle; -> RX_ACK.
- RX_ACK: drive ACK as in ADDR_ACK. Always ACK; there is no backpressure. -> RX_BYTE.
- TX_BYTE:
  - Drive the MSB as soon as the byte is latched (SCL is low).
  - Each scl_fall: shift left and drive the next bit. sda_oe = ~bit.
  - After the 8th scl_fall: release SDA -> TX_ACK.
- TX_ACK: sample SDA on scl_rise.
  - 0 (ACK): tx_req pulses on the following scl_fall, then -> TX_BYTE.
  - 1 (NACK): nack_seen pulse -> WAIT_STOP, sda_oe=0.
- WAIT_STOP: ignore SCL; wait for STOP or START.

Global overrides:
- STOP in any state: -> IDLE, sda_oe=0, busy=0, bit counter cleared, the same cycle it is detected. A partial byte is discarded with no rx_valid.
- START (repeated) in any state: -> ADDR, sda_oe=0, counter cleared. busy holds until the new address is evaluated.
- A START/STOP detected while the target drives SDA low is ignored; the target's own drive is never misread as bus framing.
- Async reset mid-transfer: all outputs return to reset values immediately and SDA is released. Bus activity after reset release is ignored until the next START.
- Simultaneous scl_fall and a STOP/START flag cannot occur (SCL must be high for framing); framing takes priority if the filter ever aligns them.

Test Plan:
- Write 1 byte: START, 0x84 (0x42+W), 0xA5, STOP -> ACK (SDA=0) on both 9th clocks; rx_valid once with rx_data=0xA5; busy falls on STOP.
- Address mismatch: START, 0x86, 0x11, STOP -> sda_oe never asserted, rx_valid and busy stay 0.
- Read 2 bytes: START, 0x85, tx_data=0x3C then 0xF0, master ACKs then NACKs -> SDA carries 0x3C then 0xF0; tx_req pulses 2x; nack_seen 1x; SDA released before STOP.
- Repeated START: write 0x84, 0x07, Sr, 0x85, read one byte (tx_data=0x99), NACK, STOP -> rx_data=0x07 then SDA carries 0x99; busy stays high throughout.
- Abort and glitch: STOP after 4 data bits -> no rx_valid, IDLE. SCL glitch shorter than FILT_LEN clocks mid-byte -> no extra bit shifted.
- Reset: assert rst while driving an ACK -> sda_oe=0 the same cycle; a subsequent full write of 0x5A is received correctly.
